// File: rtl/program_sequencer.sv
// Program sequencer: arms a program at prog_base, runs it until halt or watchdog expiry, then parks in DONE.
// Latency: start rise -> pc_load one cycle later; start fall -> first pc_advance one cycle later.
// Backpressure: stall freezes the PC and holds halt evaluation; the watchdog keeps counting through stalls.
module program_sequencer #(
   parameter int PC_WIDTH   = 12,
   parameter int CNT_WIDTH  = 16,
   parameter int WDOG_LIMIT = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  prog_base,
   input  logic                 halt,
   input  logic                 stall,
   output logic                 pc_load,
   output logic [PC_WIDTH-1:0]  pc_load_val,
   output logic                 pc_advance,
   output logic [CNT_WIDTH-1:0] instr_count,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   // Compared at 32 bits so a limit wider than the counter simply never fires.
   localparam logic [31:0]          WDOG_LAST = 32'(WDOG_LIMIT - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] wdog;
   logic [31:0]          wdog_ext;
   logic                 wdog_expire;

   assign wdog_ext    = 32'(wdog);
   assign wdog_expire = (wdog_ext == WDOG_LAST);

   // Outputs decoded from state only; pc_advance additionally gates on the live stall/halt of the current PC.
   assign pc_load    = (state == ARMED);
   assign busy       = (state == ARMED) || (state == RUN);
   assign done       = (state == DONE);
   assign pc_advance = (state == RUN) && !stall && !halt;

   // Sequencer state, latched base address, retire counter, watchdog and termination cause.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc_load_val <= '0;
         instr_count <= '0;
         wdog        <= '0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A new program clears the previous result on the arming edge.
               if (start) begin
                  state       <= ARMED;
                  pc_load_val <= prog_base;
                  instr_count <= '0;
                  wdog        <= '0;
                  timeout     <= 1'b0;
               end
            end
            ARMED: begin
               instr_count <= '0;
               wdog        <= '0;
               if (!start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (halt && !stall) begin
                  // Halt wins over a simultaneous watchdog expiry and is not retired.
                  state   <= DONE;
                  timeout <= 1'b0;
               end else begin
                  if (pc_advance && (instr_count != CNT_MAX)) begin
                     instr_count <= instr_count + 1'b1;
                  end
                  if (wdog_expire) begin
                     state   <= DONE;
                     timeout <= 1'b1;
                  end else begin
                     wdog <= wdog + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed programs on two parameterisations.
// Stimulus pushes expected end-of-program results; monitors pop them on each done rise.
// Inline checks cover reset, latency, stall freezing, saturation and async reset.
module tb_program_sequencer;

   typedef struct packed {
      logic [15:0] cnt;
      logic        to;
      logic [11:0] plv;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   // DUT A: watchdog limit 8, default widths
   logic        a_start = 1'b0, a_halt = 1'b0, a_stall = 1'b0;
   logic [11:0] a_base = '0;
   logic        a_pc_load, a_pc_advance, a_busy, a_done, a_timeout;
   logic [11:0] a_plv;
   logic [15:0] a_cnt;

   // DUT B: 4-bit counter, watchdog limit 40
   logic        b_start = 1'b0, b_halt = 1'b0, b_stall = 1'b0;
   logic [11:0] b_base = '0;
   logic        b_pc_load, b_pc_advance, b_busy, b_done, b_timeout;
   logic [11:0] b_plv;
   logic [3:0]  b_cnt;

   exp_t q_a[$];
   exp_t q_b[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   program_sequencer #(.PC_WIDTH(12), .CNT_WIDTH(16), .WDOG_LIMIT(8)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .prog_base(a_base), .halt(a_halt), .stall(a_stall),
      .pc_load(a_pc_load), .pc_load_val(a_plv), .pc_advance(a_pc_advance), .instr_count(a_cnt),
      .busy(a_busy), .done(a_done), .timeout(a_timeout)
   );

   program_sequencer #(.PC_WIDTH(12), .CNT_WIDTH(4), .WDOG_LIMIT(40)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .prog_base(b_base), .halt(b_halt), .stall(b_stall),
      .pc_load(b_pc_load), .pc_load_val(b_plv), .pc_advance(b_pc_advance), .instr_count(b_cnt),
      .busy(b_busy), .done(b_done), .timeout(b_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Monitor A: compare each completed program against the oldest expectation.
   initial begin : mon_a
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (a_done && !prev) begin
            if (q_a.size() == 0) begin
               chk("a_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q_a.pop_front();
               chk("a_done_count", 32'(a_cnt), 32'(e.cnt));
               chk("a_done_timeout", 32'(a_timeout), 32'(e.to));
               chk("a_done_plv", 32'(a_plv), 32'(e.plv));
            end
         end
         prev = a_done;
      end
   end

   // Monitor B: same for the saturating instance.
   initial begin : mon_b
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (b_done && !prev) begin
            if (q_b.size() == 0) begin
               chk("b_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q_b.pop_front();
               chk("b_done_count", 32'(b_cnt), 32'(e.cnt));
               chk("b_done_timeout", 32'(b_timeout), 32'(e.to));
               chk("b_done_plv", 32'(b_plv), 32'(e.plv));
            end
         end
         prev = b_done;
      end
   end

   initial begin : stim
      int pl;
      int adv;

      // Reset state
      tick;
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_pc_load", 32'(a_pc_load), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_timeout", 32'(a_timeout), 32'd0);
      chk("rst_plv", 32'(a_plv), 32'd0);
      chk("rst_cnt", 32'(a_cnt), 32'd0);
      chk("rst_adv", 32'(a_pc_advance), 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_busy", 32'(a_busy), 32'd0);

      // Basic run: base 0x010, start high 3 cycles, halt after 5 advances
      q_a.push_back('{cnt: 16'd5, to: 1'b0, plv: 12'h010});
      a_base = 12'h010;
      a_start = 1'b1;
      tick;
      chk("basic_pc_load_latency", 32'(a_pc_load), 32'd1);
      chk("basic_plv", 32'(a_plv), 32'h010);
      chk("basic_busy", 32'(a_busy), 32'd1);
      chk("basic_armed_adv", 32'(a_pc_advance), 32'd0);
      pl = 1;
      tick; pl += int'(a_pc_load);
      tick; pl += int'(a_pc_load);
      a_start = 1'b0;
      a_base = 12'h7FF;
      tick; pl += int'(a_pc_load);
      chk("basic_pc_load_cycles", 32'(pl), 32'd3);
      chk("basic_first_adv", 32'(a_pc_advance), 32'd1);
      adv = 0;
      for (int i = 0; i < 5; i++) begin
         adv += int'(a_pc_advance);
         tick;
      end
      chk("basic_adv_count", 32'(adv), 32'd5);
      chk("basic_cnt_before_halt", 32'(a_cnt), 32'd5);
      a_halt = 1'b1;
      #1;
      chk("basic_halt_no_adv", 32'(a_pc_advance), 32'd0);
      tick;
      a_halt = 1'b0;
      chk("basic_done", 32'(a_done), 32'd1);
      chk("basic_not_busy", 32'(a_busy), 32'd0);
      tick;
      chk("basic_done_held", 32'(a_done), 32'd1);
      chk("basic_cnt_held", 32'(a_cnt), 32'd5);

      // Back-to-back with a stall overlapping the halt
      q_a.push_back('{cnt: 16'd2, to: 1'b0, plv: 12'h200});
      a_base = 12'h200;
      a_start = 1'b1;
      tick;
      chk("b2b_done_falls", 32'(a_done), 32'd0);
      chk("b2b_cnt_cleared", 32'(a_cnt), 32'd0);
      chk("b2b_plv", 32'(a_plv), 32'h200);
      chk("b2b_pc_load", 32'(a_pc_load), 32'd1);
      a_start = 1'b0;
      tick;
      tick;
      tick;
      chk("stall_cnt_pre", 32'(a_cnt), 32'd2);
      a_stall = 1'b1;
      #1;
      chk("stall_adv0_c1", 32'(a_pc_advance), 32'd0);
      tick;
      a_halt = 1'b1;
      #1;
      chk("stall_adv0_c2", 32'(a_pc_advance), 32'd0);
      tick;
      chk("stall_halt_held_off", 32'(a_busy), 32'd1);
      chk("stall_cnt_frozen", 32'(a_cnt), 32'd2);
      a_stall = 1'b0;
      tick;
      a_halt = 1'b0;
      chk("stall_done_after_drop", 32'(a_done), 32'd1);

      // Watchdog: limit 8, no halt, expires after exactly 8 RUN cycles
      q_a.push_back('{cnt: 16'd8, to: 1'b1, plv: 12'h055});
      a_base = 12'h055;
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      tick;
      for (int i = 0; i < 7; i++) tick;
      chk("wdog_not_yet", 32'(a_done), 32'd0);
      tick;
      chk("wdog_done", 32'(a_done), 32'd1);
      chk("wdog_timeout", 32'(a_timeout), 32'd1);

      // Halt on the expiry cycle: halt wins, 7 retired
      q_a.push_back('{cnt: 16'd7, to: 1'b0, plv: 12'h0AA});
      a_base = 12'h0AA;
      a_start = 1'b1;
      tick;
      chk("rearm_timeout_clear", 32'(a_timeout), 32'd0);
      a_start = 1'b0;
      tick;
      for (int i = 0; i < 7; i++) tick;
      a_halt = 1'b1;
      tick;
      a_halt = 1'b0;
      chk("halt_vs_wdog_done", 32'(a_done), 32'd1);
      chk("halt_vs_wdog_timeout", 32'(a_timeout), 32'd0);

      // Async reset mid-RUN; start during RUN ignored; start held through reset rearms
      a_base = 12'h123;
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      tick;
      tick;
      a_start = 1'b1;
      a_base = 12'h321;
      tick;
      chk("run_ignores_start", 32'(a_pc_load), 32'd0);
      chk("run_ignores_start_busy", 32'(a_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", 32'(a_busy), 32'd0);
      chk("async_rst_adv", 32'(a_pc_advance), 32'd0);
      chk("async_rst_cnt", 32'(a_cnt), 32'd0);
      chk("async_rst_plv", 32'(a_plv), 32'd0);
      chk("async_rst_pc_load", 32'(a_pc_load), 32'd0);
      reset = 1'b0;
      q_a.push_back('{cnt: 16'd0, to: 1'b0, plv: 12'h321});
      tick;
      chk("rst_release_armed", 32'(a_pc_load), 32'd1);
      chk("rst_release_plv", 32'(a_plv), 32'h321);
      a_start = 1'b0;
      tick;
      a_halt = 1'b1;
      tick;
      a_halt = 1'b0;
      chk("immediate_halt_done", 32'(a_done), 32'd1);

      // Saturation on the 4-bit instance
      q_b.push_back('{cnt: 16'd15, to: 1'b0, plv: 12'h300});
      b_base = 12'h300;
      b_start = 1'b1;
      tick;
      b_start = 1'b0;
      tick;
      for (int i = 0; i < 15; i++) tick;
      chk("sat_reach_max", 32'(b_cnt), 32'd15);
      for (int i = 0; i < 5; i++) tick;
      chk("sat_hold_max", 32'(b_cnt), 32'd15);
      chk("sat_still_running", 32'(b_busy), 32'd1);
      b_halt = 1'b1;
      tick;
      b_halt = 1'b0;
      chk("sat_done", 32'(b_done), 32'd1);

      tick;
      tick;
      chk("queue_a_drained", 32'(q_a.size()), 32'd0);
      chk("queue_b_drained", 32'(q_b.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
